// File: rtl/instr_sequencer_if.sv
// Sequencer <-> datapath/memory bundle.
//   master : the control FSM (samples run/mem_rdy/ir, drives strobes and status)
//   slave  : the datapath/memory side (drives run/mem_rdy/ir, samples strobes)
// Signals:
//   run, mem_rdy, ir[31:0]                        -> sequencer
//   PCout, Zlowout, Zhighout, MDRout              bus drive strobes
//   MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin register load strobes
//   IncPC, Read                                   PC+1 select, memory read
//   alu_op[3:0], regin/regout[NREG-1:0]           ALU select, one-hot GPR controls
//   state[3:0], halted, illegal                   debug/status
interface instr_sequencer_if #(parameter int NREG = 16);
    logic            run;
    logic            mem_rdy;
    logic [31:0]     ir;
    logic            PCout, Zlowout, Zhighout, MDRout;
    logic            MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin;
    logic            IncPC, Read;
    logic [3:0]      alu_op;
    logic [NREG-1:0] regin;
    logic [NREG-1:0] regout;
    logic [3:0]      state;
    logic            halted;
    logic            illegal;

    modport master (
        input  run, mem_rdy, ir,
        output PCout, Zlowout, Zhighout, MDRout,
        output MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        output IncPC, Read, alu_op, regin, regout, state, halted, illegal
    );

    modport slave (
        output run, mem_rdy, ir,
        input  PCout, Zlowout, Zhighout, MDRout,
        input  MARin, PCin, MDRin, IRin, Yin, Zin, HIin, LOin,
        input  IncPC, Read, alu_op, regin, regout, state, halted, illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: control-unit FSM for the register-transfer datapath.
// Fetches an instruction (T0-T2), decodes IR[31:27], executes ALU ops (T3-T6).
// Ports:
//   clk   : clock, all state changes on rising edge
//   clr   : synchronous active-high reset (IDLE, illegal cleared)
//   bus   : instr_sequencer_if.master (run/mem_rdy/ir in; strobes, alu_op,
//           one-hot regin/regout, state, halted, illegal out)
// Optional feature: define SEQ_MULDIV_EN to decode mul/div (LO in T5, HI in T6).
// Without it mul/div are illegal and HIin/LOin/Zhighout stay 0.
module instr_sequencer #(
    parameter int NREG = 16,
    parameter int OPW  = 5
) (
    input  logic               clk,
    input  logic               clr,
    instr_sequencer_if.master  bus
);
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4 = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_HALT = 4'd8
    } state_t;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SHR  = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_SHL  = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(5'b01111);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(5'b10000);
    localparam logic [OPW-1:0] OP_NEG  = OPW'(5'b10001);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(5'b10010);
    localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);
    localparam logic [NREG-1:0] ONE    = NREG'(1);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;

    logic [OPW-1:0] opcode;
    logic [3:0]     ra, rb, rc;
    logic [3:0]     alu_code;
    logic           is_legal;   // a defined ALU instruction
    logic           is_unary;
    logic           is_halt;
`ifdef SEQ_MULDIV_EN
    logic           is_muldiv;
`endif
    logic           unused_ir_bits;

    assign opcode = bus.ir[31 -: OPW];
    assign ra     = bus.ir[26:23];
    assign rb     = bus.ir[22:19];
    assign rc     = bus.ir[18:15];
    assign unused_ir_bits = ^bus.ir[14:0];

    // IR is stable from T3 until the next T2, so decode is purely combinational.
    always_comb begin
        alu_code = 4'd0;
        is_legal = 1'b1;
        is_unary = 1'b0;
        is_halt  = 1'b0;
`ifdef SEQ_MULDIV_EN
        is_muldiv = 1'b0;
`endif
        case (opcode)
            OP_ADD:  alu_code = 4'd1;
            OP_SUB:  alu_code = 4'd2;
            OP_AND:  alu_code = 4'd3;
            OP_OR:   alu_code = 4'd4;
            OP_SHR:  alu_code = 4'd5;
            OP_SHL:  alu_code = 4'd6;
`ifdef SEQ_MULDIV_EN
            OP_MUL:  begin alu_code = 4'd7; is_muldiv = 1'b1; end
            OP_DIV:  begin alu_code = 4'd8; is_muldiv = 1'b1; end
`endif
            OP_NEG:  begin alu_code = 4'd9;  is_unary = 1'b1; end
            OP_NOT:  begin alu_code = 4'd10; is_unary = 1'b1; end
            OP_HALT: begin is_halt = 1'b1; is_legal = 1'b0; end
            default: is_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Moore outputs per state; T1 additionally depends on mem_rdy.
    always_comb begin
        state_d      = state_q;
        illegal_d    = illegal_q;
        bus.PCout    = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.MDRout   = 1'b0;
        bus.MARin    = 1'b0;
        bus.PCin     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Zin      = 1'b0;
        bus.HIin     = 1'b0;
        bus.LOin     = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Read     = 1'b0;
        bus.alu_op   = 4'd0;
        bus.regin    = '0;
        bus.regout   = '0;
        case (state_q)
            S_IDLE: if (bus.run) state_d = S_T0;
            S_T0: begin
                bus.PCout = 1'b1;
                bus.MARin = 1'b1;
                bus.IncPC = 1'b1;
                bus.Zin   = 1'b1;
                state_d   = S_T1;
            end
            S_T1: begin
                // Wait state for as long as memory needs; PC+1 commits with the data.
                bus.Read  = 1'b1;
                bus.MDRin = 1'b1;
                if (bus.mem_rdy) begin
                    bus.Zlowout = 1'b1;
                    bus.PCin    = 1'b1;
                    state_d     = S_T2;
                end
            end
            S_T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_d    = S_T3;
            end
            S_T3: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (!is_legal) begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end else if (is_unary) begin
                    bus.regout = ONE << rb;
                    bus.alu_op = alu_code;
                    bus.Zin    = 1'b1;
                    state_d    = S_T5;
                end else begin
                    bus.regout = ONE << rb;
                    bus.Yin    = 1'b1;
                    state_d    = S_T4;
                end
            end
            S_T4: begin
                bus.regout = ONE << rc;
                bus.alu_op = alu_code;
                bus.Zin    = 1'b1;
                state_d    = S_T5;
            end
            S_T5: begin
                bus.Zlowout = 1'b1;
                state_d     = bus.run ? S_T0 : S_IDLE;
`ifdef SEQ_MULDIV_EN
                if (is_muldiv) begin
                    bus.LOin = 1'b1;
                    state_d  = S_T6;
                end else begin
                    bus.regin = ONE << ra;
                end
`else
                bus.regin = ONE << ra;
`endif
            end
`ifdef SEQ_MULDIV_EN
            S_T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                state_d      = bus.run ? S_T0 : S_IDLE;
            end
`endif
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.state   = state_q;
    assign bus.halted  = (state_q == S_HALT);
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    localparam int NREG = 16;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    instr_sequencer_if #(.NREG(NREG)) bus ();
    instr_sequencer #(.NREG(NREG), .OPW(5)) dut (.clk(clk), .clr(clr), .bus(bus));

    int checks = 0;
    int fails  = 0;

    localparam logic [13:0] PCO  = 14'h2000, ZLO = 14'h1000, ZHI = 14'h0800, MDO = 14'h0400;
    localparam logic [13:0] MARI = 14'h0200, PCI = 14'h0100, MDRI = 14'h0080, IRI = 14'h0040;
    localparam logic [13:0] YI   = 14'h0020, ZI  = 14'h0010, HII = 14'h0008, LOI = 14'h0004;
    localparam logic [13:0] INC  = 14'h0002, RD  = 14'h0001;
    localparam logic [13:0] F0 = PCO | MARI | INC | ZI;
    localparam logic [13:0] F1 = RD | MDRI | ZLO | PCI;
    localparam logic [13:0] F2 = MDO | IRI;

    localparam logic [31:0] I_ADD  = 32'h18918000;  // add R1,R2,R3
    localparam logic [31:0] I_NEG  = 32'h88880000;  // neg R1,R1
    localparam logic [31:0] I_MUL  = 32'h79100000;  // mul R2,R0
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_BAD  = 32'h00000000;  // opcode 0 undefined

    wire [13:0] strb = {bus.PCout, bus.Zlowout, bus.Zhighout, bus.MDRout, bus.MARin, bus.PCin,
                        bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin, bus.IncPC, bus.Read};
    wire [55:0] obs  = {bus.state, strb, bus.alu_op, bus.regin, bus.regout, bus.halted, bus.illegal};

    function automatic logic [55:0] mk(logic [3:0] st, logic [13:0] s, logic [3:0] a,
                                       logic [15:0] ri, logic [15:0] ro, logic h, logic il);
        return {st, s, a, ri, ro, h, il};
    endfunction

    task automatic test_reset();
        clr = 1'b1; bus.run = 1'b0; bus.mem_rdy = 1'b0; bus.ir = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if (obs !== 56'h0) begin fails++; $display("FAIL reset: got %h expected %h", obs, 56'h0); end
        clr = 1'b0;
    endtask

    task automatic test_add();
        logic [1:0]  stim[$];
        logic [55:0] e[$];
        bus.ir = I_ADD;
        stim = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11,
                 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, YI, 0, 0, 16'h4, 0, 0), mk(5, ZI, 1, 0, 16'h8, 0, 0),
              mk(6, ZLO, 0, 16'h2, 0, 0, 0),
              mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0), mk(3, F2, 0, 0, 0, 0, 0),
              mk(4, YI, 0, 0, 16'h4, 0, 0), mk(5, ZI, 1, 0, 16'h8, 0, 0),
              mk(6, ZLO, 0, 16'h2, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk); bus.run = stim[i][1]; bus.mem_rdy = stim[i][0]; #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL add step %0d: got %h expected %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_wait_state();
        logic [1:0]  stim[$];
        logic [55:0] e[$];
        bus.ir = I_ADD;
        stim = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0),
              mk(2, RD | MDRI, 0, 0, 0, 0, 0), mk(2, RD | MDRI, 0, 0, 0, 0, 0),
              mk(2, RD | MDRI, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, YI, 0, 0, 16'h4, 0, 0), mk(5, ZI, 1, 0, 16'h8, 0, 0),
              mk(6, ZLO, 0, 16'h2, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk); bus.run = stim[i][1]; bus.mem_rdy = stim[i][0]; #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL wait_state step %0d: got %h expected %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_unary();
        logic [1:0]  stim[$];
        logic [55:0] e[$];
        bus.ir = I_NEG;
        stim = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, ZI, 9, 0, 16'h2, 0, 0),
              mk(6, ZLO, 0, 16'h2, 0, 0, 0), mk(0, 0, 0, 0, 0, 0, 0)};
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk); bus.run = stim[i][1]; bus.mem_rdy = stim[i][0]; #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL unary step %0d: got %h expected %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_muldiv();
        logic [1:0]  stim[$];
        logic [55:0] e[$];
        bus.ir = I_MUL;
`ifdef SEQ_MULDIV_EN
        stim = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, YI, 0, 0, 16'h4, 0, 0), mk(5, ZI, 7, 0, 16'h1, 0, 0),
              mk(6, ZLO | LOI, 0, 0, 0, 0, 0), mk(7, ZHI | HII, 0, 0, 0, 0, 0),
              mk(0, 0, 0, 0, 0, 0, 0)};
`else
        stim = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0, 0),
              mk(8, 0, 0, 0, 0, 1, 1), mk(8, 0, 0, 0, 0, 1, 1)};
`endif
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk); bus.run = stim[i][1]; bus.mem_rdy = stim[i][0]; #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL muldiv step %0d: got %h expected %h", i, obs, e[i]); end
        end
`ifndef SEQ_MULDIV_EN
        @(negedge clk); clr = 1'b1; bus.run = 1'b0;
        @(negedge clk); clr = 1'b0; #1;
        checks++;
        if (obs !== 56'h0) begin fails++; $display("FAIL muldiv clr: got %h expected %h", obs, 56'h0); end
`endif
    endtask

    task automatic test_halt();
        logic [1:0]  stim[$];
        logic [55:0] e[$];
        bus.ir = I_HALT;
        stim = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b01};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0, 0), mk(8, 0, 0, 0, 0, 1, 0),
              mk(8, 0, 0, 0, 0, 1, 0), mk(8, 0, 0, 0, 0, 1, 0), mk(8, 0, 0, 0, 0, 1, 0)};
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk); bus.run = stim[i][1]; bus.mem_rdy = stim[i][0]; #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL halt step %0d: got %h expected %h", i, obs, e[i]); end
        end
        @(negedge clk); clr = 1'b1; bus.run = 1'b0;
        @(negedge clk); clr = 1'b0; #1;
        checks++;
        if (obs !== 56'h0) begin fails++; $display("FAIL halt clr: got %h expected %h", obs, 56'h0); end
    endtask

    task automatic test_illegal();
        logic [1:0]  stim[$];
        logic [55:0] e[$];
        bus.ir = I_BAD;
        stim = '{2'b11, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        e = '{mk(0, 0, 0, 0, 0, 0, 0), mk(1, F0, 0, 0, 0, 0, 0), mk(2, F1, 0, 0, 0, 0, 0),
              mk(3, F2, 0, 0, 0, 0, 0), mk(4, 0, 0, 0, 0, 0, 0), mk(8, 0, 0, 0, 0, 1, 1)};
        for (int i = 0; i < e.size(); i++) begin
            @(negedge clk); bus.run = stim[i][1]; bus.mem_rdy = stim[i][0]; #1;
            checks++;
            if (obs !== e[i]) begin fails++; $display("FAIL illegal step %0d: got %h expected %h", i, obs, e[i]); end
        end
        @(negedge clk); clr = 1'b1; bus.run = 1'b0;
        @(negedge clk); clr = 1'b0; #1;
        checks++;
        if (obs !== 56'h0) begin fails++; $display("FAIL illegal clr: got %h expected %h", obs, 56'h0); end
    endtask

    task automatic test_clr_midstate();
        bus.ir = I_ADD;
        @(negedge clk); bus.run = 1'b1; bus.mem_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        checks++;
        if (obs !== mk(2, RD | MDRI, 0, 0, 0, 0, 0))
            begin fails++; $display("FAIL clr_mid pre: got %h expected %h", obs, mk(2, RD | MDRI, 0, 0, 0, 0, 0)); end
        clr = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (obs !== 56'h0) begin fails++; $display("FAIL clr_mid post: got %h expected %h", obs, 56'h0); end
        clr = 1'b0; bus.run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_wait_state();
        test_unary();
        test_muldiv();
        test_halt();
        test_illegal();
        test_clr_midstate();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
